// File: rtl/jhash_sched_if.sv
// jhash_sched_if: requester, core-stream and result signals of the jhash scheduler
interface jhash_sched_if #(
  parameter int NREQ = 4,
  parameter int IDW = 2
);
  logic [NREQ-1:0] req_valid;
  logic [32*NREQ-1:0] req_data;
  logic [NREQ-1:0] req_last;
  logic [NREQ-1:0] req_ready;
  logic [31:0] stream_data0;
  logic [31:0] stream_data1;
  logic [31:0] stream_data2;
  logic stream_valid;
  logic stream_done;
  logic [1:0] stream_left;
  logic stream_ack;
  logic [31:0] OC;
  logic hash_valid;
  logic [31:0] hash_value;
  logic [IDW-1:0] hash_id;
  logic hash_ready;
  modport master (
    input req_valid, req_data, req_last, stream_ack, OC, hash_ready,
    output req_ready, stream_data0, stream_data1, stream_data2, stream_valid,
    output stream_done, stream_left, hash_valid, hash_value, hash_id
  );
  modport slave (
    output req_valid, req_data, req_last, stream_ack, OC, hash_ready,
    input req_ready, stream_data0, stream_data1, stream_data2, stream_valid,
    input stream_done, stream_left, hash_valid, hash_value, hash_id
  );
endinterface

// File: rtl/jhash_sched.sv
// jhash_sched: round-robin front end packing requester key words into 3-word groups for the shared jhash core
module jhash_sched #(
  parameter int NREQ = 4,
  parameter int IDW = 2,
  parameter int MIX_LAT = 6
) (
  input logic clk,
  input logic rst,
  jhash_sched_if.master bus
);
  localparam int CW = $clog2(MIX_LAT + 1);
  typedef enum logic [2:0] {IDLE, FILL, ISSUE, WAIT_MIX, RESULT} state_t;
  state_t state, state_n;
  logic [IDW-1:0] g, rr_ptr, pick, hash_id;
  logic hit, fire, last_grp;
  logic [2:0][31:0] grp;
  logic [1:0] slot, words;
  logic [CW-1:0] cnt;
  logic [31:0] hash_value;
  logic [NREQ-1:0][31:0] din;
  logic [2*NREQ-1:0] rot;
  assign din = bus.req_data;
  // rotate so bit 0 is the requester at rr_ptr; the lowest set bit wins
  assign rot = {bus.req_valid, bus.req_valid} >> rr_ptr;
  always_comb begin
    hit = 1'b0;
    pick = '0;
    for (int i = NREQ - 1; i >= 0; i--)
      if (rot[i]) begin
        hit = 1'b1;
        pick = IDW'(int'(rr_ptr) + i >= NREQ ? int'(rr_ptr) + i - NREQ : int'(rr_ptr) + i);
      end
  end
  assign fire = state == FILL && bus.req_valid[g];
  assign bus.req_ready = (state == FILL) ? NREQ'(1) << g : '0;
  assign bus.stream_valid = state == ISSUE;
  assign bus.stream_data0 = grp[0];
  assign bus.stream_data1 = grp[1];
  assign bus.stream_data2 = grp[2];
  assign bus.stream_done = state == ISSUE && last_grp;
  assign bus.stream_left = (state == ISSUE && last_grp && words != 2'd3) ? words : 2'd0;
  assign bus.hash_valid = state == RESULT;
  assign bus.hash_value = hash_value;
  assign bus.hash_id = hash_id;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:     state_n = hit ? FILL : IDLE;
      FILL:     state_n = (fire && (slot == 2'd2 || bus.req_last[g])) ? ISSUE : FILL;
      ISSUE:    state_n = bus.stream_ack ? (last_grp ? WAIT_MIX : FILL) : ISSUE;
      WAIT_MIX: state_n = (cnt == '0) ? RESULT : WAIT_MIX;
      RESULT:   state_n = bus.hash_ready ? IDLE : RESULT;
      default:  state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      rr_ptr <= '0;
      g <= '0;
      grp <= '0;
      slot <= '0;
      words <= '0;
      last_grp <= 1'b0;
      cnt <= '0;
      hash_value <= '0;
      hash_id <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && hit) begin
        g <= pick;
        grp <= '0;
        slot <= '0;
        words <= '0;
        last_grp <= 1'b0;
      end
      if (fire) begin
        grp[slot] <= din[g];
        slot <= slot + 2'd1;
        words <= slot + 2'd1;
        last_grp <= bus.req_last[g];
      end
      if (state == ISSUE && bus.stream_ack) begin
        if (last_grp) cnt <= CW'(MIX_LAT - 1);
        else begin
          grp <= '0;
          slot <= '0;
          words <= '0;
        end
      end
      if (state == WAIT_MIX) begin
        cnt <= cnt - 1'b1;
        if (cnt == '0) begin
          hash_value <= bus.OC;
          hash_id <= g;
        end
      end
      if (state == RESULT && bus.hash_ready) rr_ptr <= (int'(g) == NREQ - 1) ? '0 : g + 1'b1;
    end
  end
endmodule

// File: tb/tb_jhash_sched.sv
// tb_jhash_sched: random keys per requester checked against a group/latency model of the scheduler
module tb_jhash_sched;
  localparam int NREQ = 4;
  localparam int IDW = 2;
  localparam int ML = 6;
  typedef struct packed {
    logic [7:0][31:0] w;
    logic [3:0] len;
  } key_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int cyc = 0;
  int tests = 0;
  int fails = 0;
  logic [31:0] oc_tab [256];
  logic [31:0] wq [NREQ][$];
  bit lq [NREQ][$];
  bit started [NREQ];
  key_t pend [NREQ][$];
  jhash_sched_if #(.NREQ(NREQ), .IDW(IDW)) dif ();
  jhash_sched #(.NREQ(NREQ), .IDW(IDW), .MIX_LAT(ML)) dut (.clk(clk), .rst(rst), .bus(dif));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  // the core's output changes every cycle, so the captured value pins down the capture cycle
  assign dif.OC = oc_tab[cyc[7:0]];
  // requester drivers: pop accepted words, then present the next word (gaps only inside a key)
  always @(posedge clk) begin
    for (int i = 0; i < NREQ; i++)
      if (dif.req_valid[i] && dif.req_ready[i]) begin
        started[i] = !lq[i][0];
        void'(wq[i].pop_front());
        void'(lq[i].pop_front());
      end
    #1;
    for (int i = 0; i < NREQ; i++) begin
      dif.req_valid[i] = 1'b0;
      dif.req_last[i] = 1'b0;
      dif.req_data[32*i +: 32] = '0;
      if (wq[i].size() > 0 && (!started[i] || $urandom_range(2) != 0)) begin
        dif.req_valid[i] = 1'b1;
        dif.req_data[32*i +: 32] = wq[i][0];
        dif.req_last[i] = lq[i][0];
      end
    end
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, "_ready"}, dif.req_ready, 0);
    chk({tag, "_sv"}, dif.stream_valid, 0);
    chk({tag, "_d0"}, dif.stream_data0, 0);
    chk({tag, "_d1"}, dif.stream_data1, 0);
    chk({tag, "_d2"}, dif.stream_data2, 0);
    chk({tag, "_done"}, dif.stream_done, 0);
    chk({tag, "_left"}, dif.stream_left, 0);
    chk({tag, "_hv"}, dif.hash_valid, 0);
    chk({tag, "_hval"}, dif.hash_value, 0);
    chk({tag, "_hid"}, dif.hash_id, 0);
  endtask
  function automatic key_t rkey(input int len);
    key_t k;
    k = '0;
    k.len = 4'(len);
    for (int j = 0; j < len; j++) k.w[j] = $urandom;
    return k;
  endfunction
  function automatic logic [31:0] ew(input key_t k, input int i);
    if (i >= int'(k.len)) return 32'h0;
    return k.w[i];
  endfunction
  task automatic submit(input int id, input key_t k);
    pend[id].push_back(k);
    for (int j = 0; j < int'(k.len); j++) begin
      wq[id].push_back(k.w[j]);
      lq[id].push_back(j == int'(k.len) - 1);
    end
  endtask
  task automatic wait_hi(input string tag, input bit hv);
    int t = 0;
    while (!(hv ? dif.hash_valid : dif.stream_valid) && t < 400) begin
      @(negedge clk);
      t++;
    end
    chk(tag, hv ? dif.hash_valid : dif.stream_valid, 1);
  endtask
  task automatic pulse_rst();
    rst = 1'b1;
    @(negedge clk);
    chk_zero("pulse");
    rst = 1'b0;
  endtask
  // expected traffic for one key: ceil(len/3) zero-padded groups, then the OC value MIX_LAT cycles after the last ack
  task automatic serve(input int id, input int ack_dly, input int rdy_dly);
    key_t k;
    int ngrp;
    int a = 0;
    logic ed;
    logic [1:0] el;
    logic [31:0] eh;
    k = pend[id].pop_front();
    ngrp = (int'(k.len) + 2) / 3;
    for (int gi = 0; gi < ngrp; gi++) begin
      wait_hi("sv_rise", 1'b0);
      ed = gi == ngrp - 1;
      el = ed ? 2'(int'(k.len) % 3) : 2'd0;
      for (int d = 0; d <= ack_dly; d++) begin
        chk("sv_hold", dif.stream_valid, 1);
        chk("d0", dif.stream_data0, ew(k, 3*gi));
        chk("d1", dif.stream_data1, ew(k, 3*gi + 1));
        chk("d2", dif.stream_data2, ew(k, 3*gi + 2));
        chk("done", dif.stream_done, ed);
        chk("left", dif.stream_left, el);
        chk("rdy_issue", dif.req_ready, 0);
        if (d < ack_dly) @(negedge clk);
      end
      dif.stream_ack = 1'b1;
      a = cyc;
      @(negedge clk);
      dif.stream_ack = 1'b0;
      chk("sv_drop", dif.stream_valid, 0);
    end
    wait_hi("hv_rise", 1'b1);
    chk("mix_lat", cyc, a + ML + 1);
    eh = oc_tab[8'(a + ML)];
    for (int d = 0; d <= rdy_dly; d++) begin
      chk("hv_hold", dif.hash_valid, 1);
      chk("hval", dif.hash_value, eh);
      chk("hid", dif.hash_id, id);
      chk("rdy_result", dif.req_ready, 0);
      if (d < rdy_dly) @(negedge clk);
    end
    dif.hash_ready = 1'b1;
    @(negedge clk);
    dif.hash_ready = 1'b0;
    chk("hv_drop", dif.hash_valid, 0);
    chk("rdy_idle", dif.req_ready, 0);
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    key_t k;
    int id;
    for (int i = 0; i < 256; i++) oc_tab[i] = $urandom;
    dif.stream_ack = 1'b0;
    dif.hash_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst = 1'b0;
    k = '0;
    k.len = 4'd3;
    k.w[0] = 32'h11;
    k.w[1] = 32'h22;
    k.w[2] = 32'h33;
    submit(0, k);
    serve(0, 0, 0);
    submit(2, rkey(4));
    serve(2, 0, 0);
    pulse_rst();
    submit(0, rkey(1));
    submit(1, rkey(1));
    submit(3, rkey(1));
    serve(0, 1, 0);
    submit(0, rkey(2));
    serve(1, 0, 2);
    serve(3, 2, 0);
    serve(0, 0, 0);
    submit(3, rkey(7));
    serve(3, 5, 0);
    submit(1, rkey(5));
    repeat (3) @(negedge clk);
    submit(2, rkey(3));
    serve(1, 1, 10);
    @(negedge clk);
    chk("rr_grant", dif.req_ready, 4'b0100);
    serve(2, 0, 0);
    k = rkey(6);
    submit(1, k);
    wait_hi("rst_sv", 1'b0);
    chk("rst_d0", dif.stream_data0, k.w[0]);
    rst = 1'b1;
    wq[1].delete();
    lq[1].delete();
    pend[1].delete();
    started[1] = 1'b0;
    @(negedge clk);
    chk_zero("rst_mid");
    rst = 1'b0;
    submit(1, k);
    serve(1, 0, 0);
    for (int n = 0; n < 8; n++) begin
      id = int'($urandom_range(NREQ - 1));
      submit(id, rkey(int'($urandom_range(8, 1))));
      serve(id, int'($urandom_range(3)), int'($urandom_range(3)));
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
